rgb_pwm_gen: RTL

- Consumes the three 8-bit RGB duty words from the PWM decoder stage and drives the three LED channel pins.
- Shares one free-running 8-bit PWM counter across all channels, advanced by a prescaler tick.
- Double-buffers duty values and updates them only at period boundaries, so switch or button changes never cause mid-period glitches.
- Emits a one-cycle period-done pulse for downstream sequencing.

---
 rtl/rgb_pwm_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB PWM generator. One shared 8-bit counter, stepped by a
// prescaler tick, is compared against double-buffered duty words. The duty
// buffers reload only at period boundaries, so the LED pins never glitch
// mid-period. A one-cycle pulse marks each completed period.
module rgb_pwm_gen #(
  parameter int PRESCALE   = 64,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] R_time_in,
  input  logic [7:0] G_time_in,
  input  logic [7:0] B_time_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       period_done
);

  localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);
  localparam logic        IDLE_LVL = ACTIVE_LOW;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        running;
  logic [15:0] pre;
  logic [7:0]  cnt;
  logic [7:0]  shadow_r, shadow_g, shadow_b;
  logic        tick, wrap, start;
  logic        raw_r, raw_g, raw_b;

  // Duty compare: full scale is forced on so 0xFF really means "always lit".
  function automatic logic duty_cmp(input logic [7:0] c, input logic [7:0] s);
    return (s == 8'hFF) ? 1'b1 : (c < s);
  endfunction

  // State register for the idle/run controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: leave idle as soon as enabled, return to idle when disabled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en)  state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Event decode and per-channel compare against the current buffers.
  always_comb begin
    running = (state == RUN);
    tick    = running && (pre == PRE_MAX);
    wrap    = tick && (cnt == 8'hFF);
    start   = en && !running;
    raw_r   = duty_cmp(cnt, shadow_r);
    raw_g   = duty_cmp(cnt, shadow_g);
    raw_b   = duty_cmp(cnt, shadow_b);
  end

  // Prescaler and PWM counter; both restart from zero on start or disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (!en || start) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 8'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // Duty buffers reload only on start or at a wrap that is not being disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
    end else if (start || (en && wrap)) begin
      shadow_r <= R_time_in;
      shadow_g <= G_time_in;
      shadow_b <= B_time_in;
    end
  end

  // Registered pins and period pulse; idle or disabled forces inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r       <= IDLE_LVL;
      led_g       <= IDLE_LVL;
      led_b       <= IDLE_LVL;
      period_done <= 1'b0;
    end else if (en && running) begin
      led_r       <= raw_r ^ ACTIVE_LOW;
      led_g       <= raw_g ^ ACTIVE_LOW;
      led_b       <= raw_b ^ ACTIVE_LOW;
      period_done <= wrap;
    end else begin
      led_r       <= IDLE_LVL;
      led_g       <= IDLE_LVL;
      led_b       <= IDLE_LVL;
      period_done <= 1'b0;
    end
  end

endmodule
